// File: rtl/fir_sched_pkg.sv
// Shared constants and types for the channel-multiplexed 3-tap FIR scheduler.
package fir_sched_pkg;

  localparam int NUM_CH_DEF = 4;
  localparam int DW_DEF     = 8;
  localparam int OW_DEF     = 16;
  localparam int NUM_TAPS   = 3;

  localparam int H0_DEF = 1;
  localparam int H1_DEF = 2;
  localparam int H2_DEF = 1;

  // Accumulator headroom above the output width; three DW*DW products never overflow it.
  localparam int SAT_GUARD = 2;

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    HOLD
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the requester after the last advanced grant has top priority.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] grant_idx;

  always_comb begin
    int  idx;
    logic found;
    // NOTE: every variable gets a value before any branch, so no latch can be inferred.
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = PW'(idx);
        found      = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (grant_idx == PW'(N - 1)) ? '0 : grant_idx + PW'(1);
    end
  end

endmodule

// File: rtl/fir_ch_sched.sv
// Time-shares one 3-tap FIR across NUM_CH channels with per-channel delay lines,
// round-robin admission, saturating output and a held result handshake.
module fir_ch_sched
  import fir_sched_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int DW     = DW_DEF,
  parameter int OW     = OW_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CH-1:0]         ch_valid,
  input  logic [NUM_CH*DW-1:0]      ch_data,
  output logic [NUM_CH-1:0]         ch_ready,
  output logic                      out_valid,
  output logic [$clog2(NUM_CH)-1:0] out_ch,
  output logic [OW-1:0]             out_data,
  input  logic                      out_ready,
  input  logic                      cfg_we,
  input  logic [1:0]                cfg_addr,
  input  logic [DW-1:0]             cfg_data,
  input  logic                      flush
);

  localparam int CW = $clog2(NUM_CH);
  localparam int AW = OW + SAT_GUARD;
  localparam logic signed [AW-1:0] SAT_MAX = AW'(2 ** (OW - 1) - 1);
  localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;

  state_t               state;
  logic                 flush_pend;
  logic signed [DW-1:0] coef [NUM_TAPS];
  logic signed [DW-1:0] snap [NUM_TAPS];
  logic signed [DW-1:0] x1   [NUM_CH];
  logic signed [DW-1:0] x2   [NUM_CH];
  logic signed [DW-1:0] x_cur;
  logic [CW-1:0]        cur_ch;
  logic [CW-1:0]        gsel;
  logic [NUM_CH-1:0]    grant;
  logic                 accept;

  logic signed [2*DW-1:0] p0, p1, p2;
  logic signed [AW-1:0]   acc;
  logic [OW-1:0]          sat;

  rr_arbiter #(.N(NUM_CH)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (ch_valid),
    .advance (accept),
    .grant   (grant)
  );

  // Admission is only open in IDLE once any pending flush has been applied.
  always_comb begin
    ch_ready = (state == IDLE && !flush_pend) ? grant : '0;
  end

  assign accept = |(ch_valid & ch_ready);

  always_comb begin
    gsel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant[i]) gsel = CW'(i);
    end
  end

  always_comb begin
    p0  = (2*DW)'(snap[0]) * (2*DW)'(x_cur);
    p1  = (2*DW)'(snap[1]) * (2*DW)'(x1[cur_ch]);
    p2  = (2*DW)'(snap[2]) * (2*DW)'(x2[cur_ch]);
    acc = AW'(p0) + AW'(p1) + AW'(p2);
    if (acc > SAT_MAX)      sat = SAT_MAX[OW-1:0];
    else if (acc < SAT_MIN) sat = SAT_MIN[OW-1:0];
    else                    sat = acc[OW-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      flush_pend <= 1'b0;
      out_valid  <= 1'b0;
      out_ch     <= '0;
      out_data   <= '0;
      x_cur      <= '0;
      cur_ch     <= '0;
      coef[0]    <= DW'(H0_DEF);
      coef[1]    <= DW'(H1_DEF);
      coef[2]    <= DW'(H2_DEF);
      for (int t = 0; t < NUM_TAPS; t++) snap[t] <= '0;
      // NOTE: the delay lines are a few flops per channel and must start clean, so they take the reset.
      for (int i = 0; i < NUM_CH; i++) begin
        x1[i] <= '0;
        x2[i] <= '0;
      end
    end else begin
      if (cfg_we && cfg_addr != 2'd3) coef[cfg_addr] <= cfg_data;
      if (flush) flush_pend <= 1'b1;

      case (state)
        IDLE: begin
          if (flush_pend) begin
            for (int i = 0; i < NUM_CH; i++) begin
              x1[i] <= '0;
              x2[i] <= '0;
            end
            flush_pend <= flush;
          end else if (accept) begin
            x_cur  <= ch_data[gsel*DW +: DW];
            cur_ch <= gsel;
            snap   <= coef;
            state  <= COMPUTE;
          end
        end
        COMPUTE: begin
          out_data   <= sat;
          out_ch     <= cur_ch;
          out_valid  <= 1'b1;
          x2[cur_ch] <= x1[cur_ch];
          x1[cur_ch] <= x_cur;
          state      <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_ch_sched.sv
// Scoreboard bench for fir_ch_sched: a cycle model predicts grants and results.
module tb_fir_ch_sched;

  logic        clk;
  logic        reset;
  logic [3:0]  ch_valid;
  logic [31:0] ch_data;
  logic [3:0]  ch_ready;
  logic        out_valid;
  logic [1:0]  out_ch;
  logic [15:0] out_data;
  logic        out_ready;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [7:0]  cfg_data;
  logic        flush;

  fir_ch_sched #(.NUM_CH(4), .DW(8), .OW(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .ch_valid  (ch_valid),
    .ch_data   (ch_data),
    .ch_ready  (ch_ready),
    .out_valid (out_valid),
    .out_ch    (out_ch),
    .out_data  (out_data),
    .out_ready (out_ready),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .flush     (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum logic [1:0] {M_IDLE, M_COMP, M_HOLD} mstate_t;
  typedef struct { int ch; int data; } res_t;

  int      total = 0;
  int      bad   = 0;
  res_t    sb[$];
  res_t    got[$];
  mstate_t m_state;
  int      m_ptr;
  bit      m_fpend;
  int      mh[3];
  int      mx1[4];
  int      mx2[4];
  int      m_acc_ch;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, $signed(obs), obs, $signed(exp), exp);
    end
  endtask

  function automatic int fir_model(int h0, int h1, int h2, int x, int a, int b);
    int s;
    s = h0 * x + h1 * a + h2 * b;
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    return s;
  endfunction

  function automatic logic [3:0] rr_pick(int p, logic [3:0] v);
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (p + k) % 4;
      if (v[i]) return 4'(1 << i);
    end
    return 4'b0;
  endfunction

  task automatic model_reset();
    m_state = M_IDLE;
    m_ptr   = 0;
    m_fpend = 1'b0;
    mh[0] = 1; mh[1] = 2; mh[2] = 1;
    for (int i = 0; i < 4; i++) begin
      mx1[i] = 0;
      mx2[i] = 0;
    end
    sb.delete();
    got.delete();
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic step();
    logic [3:0] er;
    int         idx;
    int         x;
    res_t       r;
    #1;
    m_acc_ch = -1;
    er = (m_state == M_IDLE && !m_fpend) ? rr_pick(m_ptr, ch_valid) : 4'b0;
    check("ch_ready", 32'(ch_ready), 32'(er));
    check("out_valid", 32'(out_valid), 32'(m_state == M_HOLD));
    if (m_state == M_HOLD) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'(1), 32'(0));
      end else begin
        check("out_ch", 32'(out_ch), 32'(sb[0].ch));
        check("out_data", 32'($signed(out_data)), 32'(sb[0].data));
      end
    end
    case (m_state)
      M_IDLE: begin
        if (m_fpend) begin
          for (int i = 0; i < 4; i++) begin
            mx1[i] = 0;
            mx2[i] = 0;
          end
          m_fpend = flush;
        end else begin
          if (flush) m_fpend = 1'b1;
          if (er != 4'b0) begin
            idx = 0;
            for (int i = 0; i < 4; i++) if (er[i]) idx = i;
            x      = int'($signed(ch_data[idx*8 +: 8]));
            r.ch   = idx;
            r.data = fir_model(mh[0], mh[1], mh[2], x, mx1[idx], mx2[idx]);
            sb.push_back(r);
            mx2[idx] = mx1[idx];
            mx1[idx] = x;
            m_ptr    = (idx + 1) % 4;
            m_acc_ch = idx;
            m_state  = M_COMP;
          end
        end
      end
      M_COMP: begin
        if (flush) m_fpend = 1'b1;
        m_state = M_HOLD;
      end
      default: begin
        if (flush) m_fpend = 1'b1;
        if (out_ready) begin
          if (sb.size() > 0) got.push_back(sb.pop_front());
          m_state = M_IDLE;
        end
      end
    endcase
    if (cfg_we && cfg_addr != 2'd3) mh[cfg_addr] = int'($signed(cfg_data));
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_ch_ready", 32'(ch_ready), 32'(0));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_out_ch", 32'(out_ch), 32'(0));
    check("rst_out_data", 32'(out_data), 32'(0));
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 50 && !(m_state == M_IDLE && sb.size() == 0); k++) step();
    if (!(m_state == M_IDLE && sb.size() == 0)) check("drain_timeout", 32'(0), 32'(1));
  endtask

  task automatic send(int ch, int val);
    bit done;
    done = 1'b0;
    ch_valid = 4'(1 << ch);
    ch_data[ch*8 +: 8] = 8'(val);
    for (int k = 0; k < 30 && !done; k++) begin
      step();
      if (m_acc_ch == ch) done = 1'b1;
    end
    if (!done) check("send_timeout", 32'(0), 32'(1));
    ch_valid = 4'b0;
  endtask

  task automatic write_cfg(int a, int d);
    cfg_we   = 1'b1;
    cfg_addr = 2'(a);
    cfg_data = 8'(d);
    step();
    cfg_we   = 1'b0;
  endtask

  task automatic wait_hold();
    for (int k = 0; k < 10 && m_state != M_HOLD; k++) step();
    if (m_state != M_HOLD) check("hold_timeout", 32'(0), 32'(1));
  endtask

  task automatic check_got(string tag, int idx, int ch, int data);
    if (idx < got.size()) begin
      check({tag, "_ch"}, 32'(got[idx].ch), 32'(ch));
      check({tag, "_data"}, 32'(got[idx].data), 32'(data));
    end else begin
      check({tag, "_missing"}, 32'(got.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    ch_valid  = '0;
    ch_data   = '0;
    out_ready = 1'b1;
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_data  = '0;
    flush     = 1'b0;

    // Single channel impulse-ish sequence with default taps 1,2,1.
    do_reset();
    send(0, 10);
    send(0, 20);
    send(0, 30);
    drain();
    check_got("s1_0", 0, 0, 10);
    check_got("s1_1", 1, 0, 40);
    check_got("s1_2", 2, 0, 80);

    // All channels offering continuously: strict rotation and independent delay lines.
    do_reset();
    ch_data  = {8'd4, 8'd3, 8'd2, 8'd1};
    ch_valid = 4'hF;
    for (int k = 0; k < 100 && got.size() < 12; k++) step();
    ch_valid = 4'h0;
    drain();
    for (int k = 0; k < 12; k++) begin
      if (k < got.size()) check("rr_order", 32'(got[k].ch), 32'(k % 4));
      else check("rr_missing", 32'(got.size()), 32'(12));
    end
    check_got("s2_ch2_0", 2, 2, 3);
    check_got("s2_ch2_1", 6, 2, 9);
    check_got("s2_ch2_2", 10, 2, 12);
    check_got("s2_ch0_2", 8, 0, 4);

    // Large taps and negative full-scale input: saturate low, no wrap; addr 3 is ignored.
    do_reset();
    write_cfg(0, 127);
    write_cfg(1, 127);
    write_cfg(2, 127);
    write_cfg(3, 55);
    send(1, -128);
    send(1, -128);
    send(1, -128);
    drain();
    check_got("s3_0", 0, 1, -16256);
    check_got("s3_1", 1, 1, -32512);
    check_got("s3_2", 2, 1, -32768);

    // Backpressure in HOLD: result stable, admission closed even with a channel offering.
    do_reset();
    out_ready = 1'b0;
    send(3, 9);
    wait_hold();
    ch_data[7:0] = 8'd1;
    ch_valid     = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      step();
      check("hold_data", 32'($signed(out_data)), 32'(9));
      check("hold_valid", 32'(out_valid), 32'(1));
      check("hold_ready", 32'(ch_ready), 32'(0));
    end
    ch_valid  = 4'b0;
    out_ready = 1'b1;
    drain();
    check_got("s4", 0, 3, 9);
    check("s4_count", 32'(got.size()), 32'(1));

    // Flush during HOLD: current result untouched, history cleared afterwards.
    do_reset();
    out_ready = 1'b0;
    send(0, 7);
    wait_hold();
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    step();
    out_ready = 1'b1;
    drain();
    send(0, 5);
    drain();
    check_got("s5_held", 0, 0, 7);
    check_got("s5_after", 1, 0, 5);

    // Reset while computing: no output, taps back to defaults, pointer back to channel 0.
    do_reset();
    write_cfg(0, 3);
    write_cfg(1, 3);
    write_cfg(2, 3);
    send(2, 2);
    do_reset();
    step();
    check("s6_valid", 32'(out_valid), 32'(0));
    ch_data[7:0]   = 8'd4;
    ch_data[31:24] = 8'd6;
    ch_valid       = 4'b1001;
    for (int k = 0; k < 10 && m_acc_ch < 0; k++) step();
    ch_valid = 4'b0;
    drain();
    check_got("s6_first", 0, 0, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fir_ch_sched.md
FIR_CH_SCHED -- requirements
Module: fir_ch_sched

Interface
REQ-001 Parameter NUM_CH, 4: number of input channels sharing one 3-tap FIR datapath.
REQ-002 Parameter DW, 8: signed sample and coefficient width.
REQ-003 Parameter OW, 16: signed output width.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 ch_valid  in  NUM_CH  per-channel sample-offered flag.
REQ-007 ch_data  in  NUM_CH*DW  packed signed samples; channel i in bits [i*DW +: DW].
REQ-008 ch_ready  out  NUM_CH  per-channel accept strobe.
REQ-009 out_valid  out  1  filtered result available.
REQ-010 out_ch  out  clog2(NUM_CH)  channel index of the result.
REQ-011 out_data  out  OW  signed filtered result.
REQ-012 out_ready  in  1  downstream accepts the result.
REQ-013 cfg_we, cfg_addr[1:0], cfg_data[DW-1:0]  in  coefficient write port; addr 0..2 = h0..h2; addr 3 ignored.
REQ-014 flush  in  1  request to clear all channel delay lines.

Function
REQ-015 FSM states IDLE, COMPUTE, HOLD; IDLE->COMPUTE on grant, COMPUTE->HOLD unconditionally, HOLD->IDLE on out_valid && out_ready.
REQ-016 In IDLE with any ch_valid set and no pending flush, grant exactly one channel by round-robin, highest priority being the channel after the last granted (channel 0 first after reset).
REQ-017 ch_ready is combinational, one-hot, asserted only for the granted channel in IDLE; all zero in COMPUTE and HOLD.
REQ-018 Sample is accepted on ch_valid[i] && ch_ready[i]; sample, channel index and a coefficient snapshot are registered that cycle.
REQ-019 COMPUTE: acc = h0*x + h1*x1[ch] + h2*x2[ch], products DW*2 bits signed, accumulation in OW+2 bits signed.
REQ-020 acc saturates to OW signed range (+32767 / -32768) before registering into out_data.
REQ-021 COMPUTE updates only the granted channel's delay line: x2[ch] <= x1[ch], x1[ch] <= x; other channels unchanged.
REQ-022 Latency: accept in cycle t -> out_valid=1 in cycle t+2; max throughput one sample per 3 cycles.
REQ-023 out_valid, out_ch, out_data held stable in HOLD until out_ready; out_valid=0 in IDLE and COMPUTE.
REQ-024 cfg writes update the coefficient register at the next edge in any state; the computation in flight uses the snapshot taken at acceptance.
REQ-025 Coefficient defaults h0=1, h1=2, h2=1.
REQ-026 flush sets a pending flag; in IDLE with the flag set, all x1/x2 clear to 0, the flag clears, and no grant occurs that cycle.
REQ-027 flush asserted in COMPUTE/HOLD does not disturb the current result or the COMPUTE delay-line update; it is applied on the next IDLE cycle.
REQ-028 A channel dropping ch_valid while not granted loses nothing; the round-robin pointer advances only on an accepted sample.

Reset
REQ-029 reset forces IDLE, all ch_ready=0, out_valid=0, out_ch=0, out_data=0, all delay lines 0, coefficients to defaults, flush-pending 0, round-robin pointer to channel 0.
REQ-030 reset asserted mid-operation discards the in-flight sample and result with no output handshake.

Structure
REQ-031 Package fir_sched_pkg holds NUM_CH/DW/OW defaults, default coefficients, the state enum, and the saturation width constant.
REQ-032 Round-robin grant is a sub-module rr_arbiter (inputs req, advance; output one-hot grant; pointer state internal).

Verification
REQ-033 Single channel 0, out_ready=1, samples 10,20,30 -> outputs 10, 40, 80 on ch 0, each 2 cycles after accept.
REQ-034 All 4 channels valid constantly, data = channel index+1 -> grant order 0,1,2,3,0,...; channel independence: ch2 outputs 3, 9, 12.
REQ-035 Coefficients 127,127,127, three samples -128 on ch 1 -> third output saturates to -32768, no wrap.
REQ-036 out_ready held 0 for 5 cycles in HOLD -> out_valid/out_data stable, all ch_ready=0, no new accept.
REQ-037 flush pulsed during HOLD of ch 0 -> current result delivered unchanged; next ch 0 sample 5 with defaults yields 5.
REQ-038 reset asserted in COMPUTE -> next cycle out_valid=0, coefficients 1,2,1, next grant to channel 0.
